// File: rtl/fp8_add_sequencer.sv
// Multi-cycle unsigned FP8 adder controller: order, align, add, normalize.
// Optional round-half-up in NORM when FP8_ADD_ROUND_EN is defined.
module fp8_add_sequencer #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] a_in,
  input  logic [EXP_W+MAN_W-1:0] b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] sum_out,
  output logic                   ovf_out,
  output logic                   busy
);

  localparam int W = EXP_W + MAN_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ORDER,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic             live;
  logic [W-1:0]     a_q, b_q;
  logic [EXP_W-1:0] big_exp, d;
  logic [MAN_W-1:0] big_man, small_man;
  logic [MAN_W:0]   sum;
`ifdef FP8_ADD_ROUND_EN
  logic             r;
`endif

  logic [EXP_W-1:0] a_exp, b_exp, ord_d;
  logic             a_big;

  assign a_exp = a_q[W-1:MAN_W];
  assign b_exp = b_q[W-1:MAN_W];
  assign a_big = a_exp > b_exp;
  assign ord_d = a_big ? (a_exp - b_exp) : (b_exp - a_exp);

  // live keeps in_ready low while reset is asserted and for the first edge
  assign in_ready  = (state == S_IDLE) && live;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      live  <= 1'b0;
    end else begin
      state <= nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid && in_ready) nxt = S_ORDER;
      S_ORDER: nxt = (ord_d != '0) ? S_ALIGN : S_ADD;
      S_ALIGN: if (d == EXP_W'(1)) nxt = S_ADD;
      S_ADD:   nxt = S_NORM;
      S_NORM:  nxt = S_DONE;
      S_DONE:  if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  logic [MAN_W-1:0] n_man;
  logic [EXP_W:0]   n_exp;
  logic             n_ovf;
  logic [W-1:0]     n_sum;
`ifdef FP8_ADD_ROUND_EN
  logic             n_r;
  logic [MAN_W:0]   rm;
`endif

  always_comb begin
    n_man = sum[MAN_W-1:0];
    n_exp = {1'b0, big_exp};
`ifdef FP8_ADD_ROUND_EN
    n_r = r;
    rm  = '0;
`endif
    if (sum[MAN_W]) begin
      n_man = sum[MAN_W:1];
      n_exp = {1'b0, big_exp} + 1'b1;
`ifdef FP8_ADD_ROUND_EN
      n_r = sum[0];
`endif
    end
`ifdef FP8_ADD_ROUND_EN
    rm = {1'b0, n_man} + {{MAN_W{1'b0}}, n_r};
    if (rm[MAN_W]) begin
      n_man = rm[MAN_W:1];
      n_exp = n_exp + 1'b1;
    end else begin
      n_man = rm[MAN_W-1:0];
    end
`endif
    n_ovf = n_exp[EXP_W];
    n_sum = n_ovf ? '1 : {n_exp[EXP_W-1:0], n_man};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      big_exp   <= '0;
      big_man   <= '0;
      small_man <= '0;
      d         <= '0;
      sum       <= '0;
      sum_out   <= '0;
      ovf_out   <= 1'b0;
`ifdef FP8_ADD_ROUND_EN
      r         <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q <= a_in;
            b_q <= b_in;
          end
        end
        S_ORDER: begin
          // equal exponents deliberately take B as the big operand
          big_exp   <= a_big ? a_exp : b_exp;
          big_man   <= a_big ? a_q[MAN_W-1:0] : b_q[MAN_W-1:0];
          small_man <= a_big ? b_q[MAN_W-1:0] : a_q[MAN_W-1:0];
          d         <= ord_d;
`ifdef FP8_ADD_ROUND_EN
          r         <= 1'b0;
`endif
        end
        S_ALIGN: begin
          small_man <= small_man >> 1;
          d         <= d - 1'b1;
`ifdef FP8_ADD_ROUND_EN
          r         <= small_man[0];
`endif
        end
        S_ADD: begin
          sum <= {1'b0, big_man} + {1'b0, small_man};
        end
        S_NORM: begin
          sum_out <= n_sum;
          ovf_out <= n_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_add_sequencer.sv
// Self-checking bench for fp8_add_sequencer against an arithmetic model.
module tb_fp8_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in, b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_out;
  logic       ovf_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  fp8_add_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .ovf_out   (ovf_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // value = man * 2^exp; small operand is truncated by the exponent gap
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] s, output logic o,
                                output int d);
    int ea, eb, ma, mb, be, bm, sm, r, t, e, m;
    ea = int'(a[7:5]); ma = int'(a[4:0]);
    eb = int'(b[7:5]); mb = int'(b[4:0]);
    if (ea > eb) begin be = ea; bm = ma; sm = mb; d = ea - eb; end
    else begin be = eb; bm = mb; sm = ma; d = eb - ea; end
    r = (d > 0) ? ((sm >> (d - 1)) & 1) : 0;
    t = bm + (sm >> d);
    if (t >= 32) begin m = t / 2; r = t % 2; e = be + 1; end
    else begin m = t; e = be; end
`ifdef FP8_ADD_ROUND_EN
    m = m + r;
    if (m == 32) begin m = 16; e = e + 1; end
`endif
    if (e > 7) begin s = 8'hFF; o = 1'b1; end
    else begin s = 8'((e << 5) | m); o = 1'b0; end
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input int stall, input bit junk,
                       output logic [7:0] s, output logic o,
                       output int lat, output int serr);
    serr = 0;
    lat = -1;
    s = 8'hxx;
    o = 1'bx;
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    if (junk) begin a_in = 8'($urandom); b_in = 8'($urandom); end
    else in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; break; end
    end
    if (lat < 0) begin in_valid = 1'b0; return; end
    s = sum_out;
    o = ovf_out;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || sum_out !== s || ovf_out !== o ||
          in_ready !== 1'b0) serr++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ovf_out !== 1'b0 ||
        sum_out !== 8'h00 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: ov=%b busy=%b ovf=%b sum=%h rdy=%b need 0 0 0 00 0",
               out_valid, busy, ovf_out, sum_out, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b need 1", in_ready);
    end
  endtask

  task automatic test_equal_exp;
    logic [7:0] s; logic o; int lat, serr;
    do_op(8'h45, 8'h4A, 0, 1'b0, s, o, lat, serr);
    checks++;
    if (s !== 8'h4F || o !== 1'b0) begin
      errors++;
      $display("FAIL equal_exp: got %h/%b need 4f/0", s, o);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL equal_lat: got %0d need 4", lat);
    end
  endtask

  task automatic test_swap_align_stall;
    logic [7:0] s; logic o; int lat, serr;
    do_op(8'h08, 8'h62, 5, 1'b0, s, o, lat, serr);
    checks++;
    if (s !== 8'h63 || o !== 1'b0) begin
      errors++;
      $display("FAIL swap_align: got %h/%b need 63/0", s, o);
    end
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL swap_lat: got %0d need 7", lat);
    end
    checks++;
    if (serr !== 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles need 0", serr);
    end
  endtask

  task automatic test_carry_ovf;
    logic [7:0] s; logic o; int lat, serr;
    do_op(8'h3F, 8'h21, 0, 1'b0, s, o, lat, serr);
    checks++;
    if (s !== 8'h50 || o !== 1'b0) begin
      errors++;
      $display("FAIL carry_norm: got %h/%b need 50/0", s, o);
    end
    do_op(8'hFF, 8'hE1, 0, 1'b0, s, o, lat, serr);
    checks++;
    if (s !== 8'hFF || o !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got %h/%b need ff/1", s, o);
    end
  endtask

  task automatic test_round;
    logic [7:0] s, e; logic o, eo; int lat, serr, d;
    model(8'h21, 8'h03, e, eo, d);
    do_op(8'h21, 8'h03, 0, 1'b0, s, o, lat, serr);
    checks++;
`ifdef FP8_ADD_ROUND_EN
    if (s !== 8'h23 || e !== 8'h23) begin
`else
    if (s !== 8'h22 || e !== 8'h22) begin
`endif
      errors++;
      $display("FAIL round: got %h model %h", s, e);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] s; logic o; int lat, serr;
    @(negedge clk);
    a_in = 8'h08; b_in = 8'hE2; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
        sum_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: busy=%b ov=%b rdy=%b sum=%h need 0 0 0 00",
               busy, out_valid, in_ready, sum_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    do_op(8'h45, 8'h4A, 0, 1'b0, s, o, lat, serr);
    checks++;
    if (s !== 8'h4F || o !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL after_reset: got %h/%b lat %0d need 4f/0 lat 4", s, o, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b, s, e; logic o, eo; int lat, serr, d;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      model(a, b, e, eo, d);
      do_op(a, b, int'($urandom_range(0, 3)), 1'b1, s, o, lat, serr);
      checks++;
      if (s !== e || o !== eo) begin
        errors++;
        $display("FAIL rand_result: a=%h b=%h got %h/%b need %h/%b",
                 a, b, s, o, e, eo);
      end
      checks++;
      if (lat !== 4 + d || serr !== 0) begin
        errors++;
        $display("FAIL rand_timing: a=%h b=%h lat %0d serr %0d need lat %0d serr 0",
                 a, b, lat, serr, 4 + d);
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_idle: busy=%b rdy=%b need 0 1", busy, in_ready);
      end
    end
  endtask

  initial begin
    test_reset;
    test_equal_exp;
    test_swap_align_stall;
    test_carry_ovf;
    test_round;
    test_reset_mid_op;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp8_add_sequencer.md
# fp8_add_sequencer

Multi-cycle controller that sequences unsigned 8-bit floating-point addition (value = mantissa × 2^exponent, exponent in bits [7:5], mantissa in bits [4:0]) through its ordering, alignment, add and normalize steps. It sits between the operand source and the result consumer, with valid/ready handshakes on both sides. It owns the shared alignment shifter and adder, so one operation is in flight at a time.

## Interface
- EXP_W, 3, exponent field width; operand width is EXP_W+MAN_W
- MAN_W, 5, mantissa field width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a_in  in  8  operand A, format {exp, man}
- b_in  in  8  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum_out  out  8  result {exp, man}
- ovf_out  out  1  exponent overflow; result saturated
- busy  out  1  FSM not in IDLE

## Operation
- One clock domain (clk); reset is asynchronous and active-low (rst_n).
- States: IDLE, ORDER, ALIGN, ADD, NORM, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a_in and b_in, then go to ORDER.
- ORDER: big-number-first swap. If exp(A) > exp(B), big=A and small=B; otherwise big=B and small=A (equal exponents take B as big). Load d = exp(big) − exp(small). Go to ALIGN if d≠0, else ADD.
- ALIGN: each cycle, shift the small mantissa right by 1, store the shifted-out bit as R, and decrement d. Leave when d reaches 0. There is no early exit, even if the small mantissa reaches zero.
- ADD: compute a 6-bit (MAN_W+1) sum = big_man + small_man. Go to NORM.
- NORM: if sum carry is set, mantissa = sum>>1, R = sum[0], and exp = exp(big)+1; otherwise mantissa = sum[4:0] and exp = exp(big). Any exponent increment beyond 7 (2^EXP_W−1) gives sum_out=8'hFF and ovf_out=1. Go to DONE.
- DONE: out_valid=1. sum_out and ovf_out are held stable until out_ready=1, then return to IDLE.
- Mantissas are unsigned. There is no left-normalization and no denormal handling.

## Timing
- Reset values: in_ready=0 while rst_n=0, then 1 in IDLE. out_valid=0, sum_out=8'h00, ovf_out=0, busy=0, state=IDLE.
- Acceptance at edge k puts the FSM in ORDER for the next cycle. out_valid first goes high in cycle k+4+d, where d is in 0..7.
- in_ready=0 in every state except IDLE. No accept is possible in the same cycle as a DONE handshake; the earliest next accept is the cycle after.
- out_valid stays high across out_ready=0 stalls of any length, with outputs unchanged.
- rst_n low in any state (including ALIGN and DONE) forces IDLE and the reset output values immediately, without waiting for clk. Partial results are discarded.
- in_valid while busy is ignored and not queued.

## Configuration
- FP8_ADD_ROUND_EN defined: NORM applies round-half-up by adding R to the final mantissa. If that makes the mantissa 32, it shifts right by 1 and increments the exponent once more, subject to the same overflow saturation. All of this happens in the same NORM cycle, so latency is unchanged.
- FP8_ADD_ROUND_EN undefined: truncation. R is ignored and need not be stored.

## Test plan
- Reset: hold rst_n=0 → out_valid=0, sum_out=8'h00, ovf_out=0, busy=0. Release rst_n → in_ready=1 on the next cycle.
- Equal exponents: a=8'h45, b=8'h4A → sum_out=8'h4F, ovf_out=0, out_valid 4 cycles after accept.
- Swap and align: a=8'h08, b=8'h62 (d=3) → sum_out=8'h63, out_valid 7 cycles after accept. Holding out_ready=0 for 5 cycles → output stable and in_ready=0 throughout.
- Carry normalize and overflow:
  - a=8'h3F, b=8'h21 → 8'h50, ovf_out=0.
  - a=8'hFF, b=8'hE1 → 8'hFF, ovf_out=1.
- Rounding: a=8'h21, b=8'h03 → 8'h22 without FP8_ADD_ROUND_EN, 8'h23 with it.
- Reset mid-operation: a=8'h08, b=8'hE2, pull rst_n low during ALIGN → busy=0 and out_valid=0 asynchronously. The next operation after release, a=8'h45, b=8'h4A, still gives 8'h4F.
